// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the branch-offset LUT, and runs the
// start/done execution handshake and the retired-instruction counter.
module fetch_unit #(
    parameter int PW = 10,
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] start_addr,
    input  logic [PW-1:0] last_addr,
    input  logic          stall,
    input  logic          branch,
    input  logic [1:0]    how_high,
    input  logic          lut_we,
    input  logic [1:0]    lut_addr,
    input  logic [PW-1:0] lut_data,
    input  logic [IW-1:0] rom_data,
    output logic [PW-1:0] prog_ctr,
    output logic [IW-1:0] instr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        pc_q, pc_d;
    logic [PW-1:0]        last_q, last_d;
    logic [CW-1:0]        ret_q, ret_d;
    logic [3:0][PW-1:0]   lut_q, lut_d;

    logic                 retire;
    logic                 at_last;
    logic [PW-1:0]        pc_seq;
    logic [PW-1:0]        pc_br;
    logic [CW-1:0]        ret_inc;

    // Offsets are PW-bit two's complement, so a plain PW-bit add already
    // gives the sign-extended sum modulo 2**PW in both directions.
    assign pc_seq  = pc_q + PW'(1);
    assign pc_br   = pc_q + lut_q[how_high];
    assign ret_inc = (ret_q == '1) ? ret_q : ret_q + CW'(1);
    assign retire  = (state_q == S_RUN) && !stall;
    assign at_last = (pc_q == last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            ret_q   <= '0;
            lut_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            ret_q   <= ret_d;
            lut_q   <= lut_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        ret_d   = ret_q;
        lut_d   = lut_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // LUT is only writable while no program runs; a write on the
                // start cycle lands before the first RUN cycle reads it.
                if (lut_we)
                    lut_d[lut_addr] = lut_data;
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = start_addr;
                    last_d  = last_addr;
                    ret_d   = '0;
                end
            end
            S_RUN: begin
                if (retire) begin
                    ret_d = ret_inc;
                    if (branch)
                        pc_d = pc_br;
                    else if (at_last)
                        state_d = S_DONE;
                    else
                        pc_d = pc_seq;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign prog_ctr = pc_q;
    assign running  = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign retired  = ret_q;
    assign instr    = running ? rom_data : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the program counter (PC) and a 4-entry branch-offset lookup table (LUT) indexed by the decoder's 2-bit how_high field.
- Runs a start/done program-execution handshake and a retired-instruction counter.
- PC addresses the external combinational instruction ROM; the 9-bit ROM word is forwarded to the decoder, and the decoder's Branch/how_high come back to steer the next PC.

Parameters:
- PW, 10, PC width in bits (instruction memory depth 2**PW).
- IW, 9, instruction width in bits.
- CW, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin execution at start_addr.
- start_addr  in  PW  first PC of the program, sampled on accepted start.
- last_addr  in  PW  final PC of the program, sampled on accepted start.
- stall  in  1  hold PC; no retire this cycle.
- branch  in  1  taken-branch indication from decoder (Branch output).
- how_high  in  2  LUT index from decoder.
- lut_we  in  1  LUT write enable (honoured only in IDLE or DONE).
- lut_addr  in  2  LUT write index.
- lut_data  in  PW  LUT write data: signed two's-complement PC offset.
- rom_data  in  IW  instruction word from instruction ROM at prog_ctr.
- prog_ctr  out  PW  current PC to ROM.
- instr  out  IW  rom_data when running, else all zeros (NOP-safe).
- running  out  1  high in RUN.
- done  out  1  high in DONE, held until next accepted start or reset.
- retired  out  CW  instructions retired since last accepted start.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE, prog_ctr=0, retired=0, all LUT entries=0.
  - running=0, done=0, instr=0.
  - Reset mid-RUN aborts immediately; no done pulse.
- States:
  - IDLE --start--> RUN
  - RUN --(retire at last_addr)--> DONE
  - DONE --start--> RUN
  - start while in RUN is ignored.
- Accepted start (IDLE/DONE, start=1):
  - Next cycle: prog_ctr=start_addr, retired=0, running=1, done=0.
  - last_addr is latched internally.
- RUN, stall=1: prog_ctr and retired hold. instr still shows rom_data.
- RUN, stall=0 (a retire):
  - retired increments by 1, saturating at all-ones.
  - If branch=1: prog_ctr <= prog_ctr + LUT[how_high], sign-extended offset, modulo 2**PW (wrap both directions).
  - Else: prog_ctr <= prog_ctr + 1, modulo 2**PW.
  - If the retiring PC equals latched last_addr and branch=0: go to DONE, prog_ctr holds, done=1 from next cycle. The last instruction is counted.
  - A taken branch at last_addr does not terminate; the branch wins.
- branch and how_high are ignored outside RUN and while stall=1.
- LUT writes:
  - Take effect next cycle, only in IDLE/DONE; ignored in RUN.
  - A write coinciding with an accepted start is performed; the new entry is visible from the first RUN cycle.
- Combinational outputs: instr = running ? rom_data : 0. All other outputs are registered.
- Latency: a PC update is visible one cycle after the retiring edge.

Test Plan:
- Sequential run: reset; start with start_addr=5, last_addr=8; no branches or stalls -> prog_ctr 5,6,7,8 on successive cycles; done=1 on the cycle after PC 8 retires; retired=4; running=0.
- Branch both directions: LUT[2]=+3, LUT[1]=-2 (10'h3FE); run from 0 with last_addr=20; branch with how_high=2 at PC 4 -> PC 7; branch with how_high=1 at PC 7 -> PC 5.
- Wrap-around: start_addr=1023, LUT[0]=+2; branch with how_high=0 at PC 1023 -> PC 1; unbranched step from 1023 -> 0.
- Stall and late writes: stall high 3 cycles at PC 6 -> prog_ctr stays 6 and retired is unchanged; a lut_we pulse during RUN leaves the LUT unchanged, checked by reading back via a branch after restart.
- Branch at last_addr: last_addr=9, branch taken at 9 with offset -4 -> PC 5, no done. Re-reaching 9 without branch -> DONE. Start during RUN is ignored.
- Reset mid-run: assert reset at PC 12 -> next cycle prog_ctr=0, retired=0, done=0, instr=0, LUT zeroed. A new start works normally afterwards.
